// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 7-segment scan controller and its sub-blocks.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-high segment pattern {dp,g,f,e,d,c,b,a}; decimal point always off.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  always_comb begin
    seg = 8'h00;
    case (hex)
      4'h0: seg = 8'h3F;
      4'h1: seg = 8'h06;
      4'h2: seg = 8'h5B;
      4'h3: seg = 8'h4F;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'h6D;
      4'h6: seg = 8'h7D;
      4'h7: seg = 8'h07;
      4'h8: seg = 8'h7F;
      4'h9: seg = 8'h6F;
      4'hA: seg = 8'h77;
      4'hB: seg = 8'h7C;
      4'hC: seg = 8'h39;
      4'hD: seg = 8'h5E;
      4'hE: seg = 8'h79;
      4'hF: seg = 8'h71;
    endcase
    seg[SEG_DP] = 1'b0;
  end

endmodule

// File: rtl/scan_divider.sv
// Slot divider: free-running 0..DIV-1 counter, slot_tick on the last count.
module scan_divider
  import seg_pkg::*;
#(
  parameter  int DIV   = 50000,
  localparam int CNT_W = idx_w(DIV)
) (
  input  logic clk,
  input  logic rst,
  output logic slot_tick
);

  logic [CNT_W-1:0] div_cnt;

  assign slot_tick = (div_cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (slot_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-seg scan controller with tear-free frame-boundary commit.
// Optional per-digit blinking is built in when SEG_BLINK_EN is defined.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG         = 8,
  parameter int DIV          = 50000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] disp_data,
  input  logic [NDIG-1:0]   disp_en,
`ifdef SEG_BLINK_EN
  input  logic [NDIG-1:0]   blink_mask,
`endif
  input  logic              load,
  output logic              busy,
  output logic [NDIG-1:0]   an_n,
  output logic [7:0]        seg_n,
  output logic              frame_tick
);

  localparam int IDX_W = idx_w(NDIG);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NDIG - 1);

  if (NDIG < 1 || NDIG > 8 || DIV < 1 || BLINK_FRAMES < 1) begin : g_param_check
    $error("seg_scan_ctrl: parameter out of legal range");
  end

  logic                 slot_tick;
  logic                 frame_end;
  logic [IDX_W-1:0]     idx;
  logic                 pending;
  logic [NDIG-1:0][3:0] stg_data;
  logic [NDIG-1:0][3:0] act_data;
  logic [NDIG-1:0]      stg_en;
  logic [NDIG-1:0]      act_en;
  logic [3:0]           cur_hex;
  logic [7:0]           cur_seg;
  logic                 blink_dark;
  logic                 lit;

  scan_divider #(.DIV(DIV)) u_div (
    .clk       (clk),
    .rst       (rst),
    .slot_tick (slot_tick)
  );

  assign frame_end = slot_tick && (idx == LAST);
  assign cur_hex   = act_data[idx];

  hex7seg u_dec (
    .hex (cur_hex),
    .seg (cur_seg)
  );

`ifdef SEG_BLINK_EN
  localparam int FRM_W = idx_w(BLINK_FRAMES);

  logic [NDIG-1:0]  stg_mask;
  logic [NDIG-1:0]  act_mask;
  logic [FRM_W-1:0] frm_cnt;
  logic             blink_phase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frm_cnt     <= '0;
      blink_phase <= 1'b0;
      stg_mask    <= '0;
      act_mask    <= '0;
    end else begin
      if (load && !pending) stg_mask <= blink_mask;
      if (frame_end) begin
        act_mask <= stg_mask;
        if (frm_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
          frm_cnt     <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frm_cnt <= frm_cnt + FRM_W'(1);
        end
      end
    end
  end

  assign blink_dark = blink_phase && act_mask[idx];
`else
  assign blink_dark = 1'b0;
`endif

  assign lit = act_en[idx] && !blink_dark;

  // The active bank and idx both change on the frame-end edge, so the first
  // slot computed from new data is digit 0 of the next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx        <= '0;
      pending    <= 1'b0;
      stg_data   <= '0;
      stg_en     <= '0;
      act_data   <= '0;
      act_en     <= '0;
      busy       <= 1'b0;
      frame_tick <= 1'b0;
      an_n       <= '1;
      seg_n      <= SEG_BLANK;
    end else begin
      if (slot_tick) idx <= (idx == LAST) ? '0 : idx + IDX_W'(1);

      if (load && !pending) begin
        stg_data <= disp_data;
        stg_en   <= disp_en;
        pending  <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end

      if (frame_end) begin
        act_data <= stg_data;
        act_en   <= stg_en;
      end

      busy       <= pending;
      frame_tick <= frame_end;
      an_n       <= lit ? ~(NDIG'(1) << idx) : '1;
      seg_n      <= lit ? ~cur_seg : SEG_BLANK;
    end
  end

endmodule
